ex_lsu_stage: RTL and testbench

- Parametrised EX-stage load/store unit. It replaces the fixed 32-bit, single-cycle SRAM store path with a req/addr_ok/data_ok bus handshake.
- Takes the computed address and operation from the ALU side, checks alignment, and builds width-generic byte strobes and replicated write data.
- Issues the bus request, tracks outstanding transactions, and hands a descriptor to MEM through a valid/ready register slice.
- Supports pipeline flush, including cancelling responses for requests already issued.

---
 rtl/ex_lsu_stage_pkg.sv | 29 ++
 rtl/ex_lsu_stage_if.sv | 31 +++
 rtl/ex_lsu_stage_strobe_gen.sv | 62 ++++++
 rtl/ex_lsu_stage.sv | 175 +++++++++++++++++
 tb/tb_ex_lsu_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_lsu_stage_pkg.sv
// ex_lsu_stage_pkg
// Shared definitions for the EX-stage load/store unit:
//   lsu_size_t  - access size encoding (log2 of the byte count)
//   SZ_B..SZ_D  - named size encodings
//   lsu_state_t - request-side FSM states
//   lsu_desc_t  - layout of the descriptor handed to MEM
package ex_lsu_stage_pkg;

    typedef logic [1:0] lsu_size_t;

    localparam lsu_size_t SZ_B = 2'd0;
    localparam lsu_size_t SZ_H = 2'd1;
    localparam lsu_size_t SZ_W = 2'd2;
    localparam lsu_size_t SZ_D = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } lsu_state_t;

    // MSB first: ale, is_store, size[1:0], is_signed
    typedef struct packed {
        logic      ale;
        logic      is_store;
        lsu_size_t size;
        logic      is_signed;
    } lsu_desc_t;

endpackage

// File: rtl/ex_lsu_stage_if.sv
// ex_lsu_stage_if
// Request/response bus between the LSU and the data memory side.
//   req, req_wr, req_size, req_addr, req_wstrb, req_wdata : request (LSU drives)
//   addr_ok : request accepted this cycle (memory drives)
//   data_ok : one response returned this cycle, in issue order (memory drives)
// Modports: master = LSU side, slave = memory side.
interface ex_lsu_stage_if
    import ex_lsu_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                req;
    logic                req_wr;
    lsu_size_t           req_size;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W/8-1:0] req_wstrb;
    logic [DATA_W-1:0]   req_wdata;
    logic                addr_ok;
    logic                data_ok;

    modport master (
        output req, req_wr, req_size, req_addr, req_wstrb, req_wdata,
        input  addr_ok, data_ok
    );

    modport slave (
        input  req, req_wr, req_size, req_addr, req_wstrb, req_wdata,
        output addr_ok, data_ok
    );
endinterface

// File: rtl/ex_lsu_stage_strobe_gen.sv
// ex_lsu_stage_strobe_gen
// Combinational byte-strobe / write-data builder with alignment check.
//   size      in  access size (log2 bytes)
//   is_store  in  strobes are only produced for stores
//   offset    in  address bits below the bus width
//   wdata     in  LSB-aligned store data
//   wstrb     out byte enables for the addressed lanes
//   wdata_rep out store data replicated across every lane group
//   ale       out size wider than the bus, or address not size-aligned
module ex_lsu_stage_strobe_gen
    import ex_lsu_stage_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  lsu_size_t                   size,
    input  logic                        is_store,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W/8-1:0]         wstrb,
    output logic [DATA_W-1:0]           wdata_rep,
    output logic                        ale
);
    localparam int        STRB_W   = DATA_W / 8;
    localparam int        OFFW     = $clog2(STRB_W);
    localparam lsu_size_t MAX_SIZE = 2'(OFFW);

    logic [3:0]        bytes;
    logic [OFFW-1:0]   amask;
    logic [STRB_W-1:0] base;
    logic [2:0]        lane;

    assign bytes = 4'd1 << size;
    assign amask = OFFW'(bytes - 4'd1);
    assign ale   = (size > MAX_SIZE) | (|(offset & amask));

    // Contiguous run of 'bytes' ones starting at lane 0; oversize accesses
    // saturate to the full bus and are rejected through ale anyway.
    always_comb begin
        base = '1;
        case (size)
            SZ_B:    base = STRB_W'(8'h01);
            SZ_H:    base = STRB_W'(8'h03);
            SZ_W:    base = STRB_W'(8'h0f);
            default: base = '1;
        endcase
    end

    assign wstrb = is_store ? (base << offset) : '0;

    // Each output byte lane takes source byte (lane mod bytes), so the
    // memory can pick the data up from whichever lanes the strobes enable.
    always_comb begin
        wdata_rep = '0;
        lane      = '0;
        for (int i = 0; i < STRB_W; i++) begin
            lane = 3'(i) & 3'(bytes - 4'd1);
            wdata_rep[8*i +: 8] = wdata[8*lane +: 8];
        end
    end

endmodule

// File: rtl/ex_lsu_stage.sv
// ex_lsu_stage
// EX-stage load/store unit: alignment check, strobe build, bus request with
// outstanding-transaction tracking, and a one-entry descriptor slot to MEM.
//   clk, reset         clock and asynchronous active-high reset
//   in_*               op from EX (valid/ready handshake)
//   flush              kill everything younger than MEM/WB
//   bus                request/response bus (master side)
//   resp_fwd           current data_ok belongs to a live op
//   out_*              descriptor to MEM (valid/ready handshake)
//   outst_cnt          issued but not yet answered requests
module ex_lsu_stage
    import ex_lsu_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 2
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_is_store,
    input  lsu_size_t                   in_size,
    input  logic                        in_signed,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [DATA_W-1:0]           in_wdata,
    input  logic                        flush,
    ex_lsu_stage_if.master              bus,
    output logic                        resp_fwd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_ale,
    output logic                        out_is_store,
    output lsu_size_t                   out_size,
    output logic                        out_signed,
    output logic [$clog2(DATA_W/8)-1:0] out_offset,
    output logic [2:0]                  outst_cnt
);
    localparam int         STRB_W  = DATA_W / 8;
    localparam int         OFFW    = $clog2(STRB_W);
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

    lsu_state_t        state;
    logic              flushed;
    logic              lat_wr;
    lsu_size_t         lat_size;
    logic              lat_signed;
    logic [ADDR_W-1:0] lat_addr;
    logic [STRB_W-1:0] lat_wstrb;
    logic [DATA_W-1:0] lat_wdata;
    lsu_desc_t         out_desc;
    logic [2:0]        cancel_cnt;

    logic [STRB_W-1:0] gen_wstrb;
    logic [DATA_W-1:0] gen_wdata;
    logic              gen_ale;
    logic              accept;
    logic              issue;
    logic              issue_dead;
    logic              slot_cancel;
    logic              dec;
    logic              drop;

    ex_lsu_stage_strobe_gen #(.DATA_W(DATA_W)) u_strobe_gen (
        .size      (in_size),
        .is_store  (in_is_store),
        .offset    (in_addr[OFFW-1:0]),
        .wdata     (in_wdata),
        .wstrb     (gen_wstrb),
        .wdata_rep (gen_wdata),
        .ale       (gen_ale)
    );

    assign in_ready = (state == ST_IDLE) & ~flush & (outst_cnt < MAX_CNT)
                    & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    assign issue      = (state == ST_REQ) & bus.addr_ok;
    assign issue_dead = issue & (flushed | flush);
    // The slot only ever holds the youngest issued op, and responses come
    // back in order, so its response is still owed exactly when more
    // responses are owed than the one arriving this cycle.
    assign slot_cancel = flush & out_valid & ~out_desc.ale
                       & (outst_cnt > {2'b00, bus.data_ok});
    assign dec  = bus.data_ok & (outst_cnt != 3'd0);
    assign drop = bus.data_ok & (cancel_cnt != 3'd0);

    assign resp_fwd = bus.data_ok & (cancel_cnt == 3'd0);

    assign bus.req       = (state == ST_REQ);
    assign bus.req_wr    = lat_wr;
    assign bus.req_size  = lat_size;
    assign bus.req_addr  = lat_addr;
    assign bus.req_wstrb = lat_wstrb;
    assign bus.req_wdata = lat_wdata;

    assign out_ale      = out_desc.ale;
    assign out_is_store = out_desc.is_store;
    assign out_size     = out_desc.size;
    assign out_signed   = out_desc.is_signed;

    // Request FSM plus the descriptor slot. Once raised, req stays up until
    // addr_ok even across a flush; a flushed request is still issued but
    // its descriptor is discarded and its response is marked for dropping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            flushed    <= 1'b0;
            lat_wr     <= 1'b0;
            lat_size   <= SZ_B;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wstrb  <= '0;
            lat_wdata  <= '0;
            out_valid  <= 1'b0;
            out_desc   <= '0;
            out_offset <= '0;
        end else begin
            if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && gen_ale) begin
                        out_valid  <= 1'b1;
                        out_desc   <= '{ale: 1'b1, is_store: in_is_store,
                                        size: in_size, is_signed: in_signed};
                        out_offset <= in_addr[OFFW-1:0];
                    end else if (accept) begin
                        state      <= ST_REQ;
                        flushed    <= 1'b0;
                        lat_wr     <= in_is_store;
                        lat_size   <= in_size;
                        lat_signed <= in_signed;
                        lat_addr   <= in_addr;
                        lat_wstrb  <= gen_wstrb;
                        lat_wdata  <= gen_wdata;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        flushed <= 1'b1;
                    end
                    if (bus.addr_ok) begin
                        state <= ST_IDLE;
                        if (!(flushed || flush)) begin
                            out_valid  <= 1'b1;
                            out_desc   <= '{ale: 1'b0, is_store: lat_wr,
                                            size: lat_size, is_signed: lat_signed};
                            out_offset <= lat_addr[OFFW-1:0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (flush) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Outstanding and cancelled-response counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outst_cnt  <= '0;
            cancel_cnt <= '0;
        end else begin
            outst_cnt  <= outst_cnt + {2'b00, issue} - {2'b00, dec};
            cancel_cnt <= cancel_cnt + {2'b00, issue_dead}
                        + {2'b00, slot_cancel} - {2'b00, drop};
        end
    end

endmodule

// File: tb/tb_ex_lsu_stage.sv
// tb_ex_lsu_stage
// Directed bench for ex_lsu_stage. A 32-bit instance is checked every cycle
// against a transaction-level model (queue of in-flight responses with a
// live flag, one pending request, one descriptor slot); a 64-bit instance
// gets hand-computed checks for the wide-bus strobe cases.
module tb_ex_lsu_stage;
    import ex_lsu_stage_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit instance
    logic        in_valid, in_ready, in_is_store, in_signed, flush, out_ready;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic        resp_fwd, out_valid, out_ale, out_is_store, out_signed;
    logic [1:0]  out_size, out_offset;
    logic [2:0]  outst_cnt;

    ex_lsu_stage_if #(.DATA_W(32), .ADDR_W(32)) bus32();

    ex_lsu_stage #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
        .in_wdata(in_wdata), .flush(flush), .bus(bus32),
        .resp_fwd(resp_fwd), .out_valid(out_valid), .out_ready(out_ready),
        .out_ale(out_ale), .out_is_store(out_is_store), .out_size(out_size),
        .out_signed(out_signed), .out_offset(out_offset), .outst_cnt(outst_cnt)
    );

    // 64-bit instance
    logic        x_in_valid, x_in_ready, x_in_is_store, x_in_signed, x_flush, x_out_ready;
    logic [1:0]  x_in_size;
    logic [31:0] x_in_addr;
    logic [63:0] x_in_wdata;
    logic        x_resp_fwd, x_out_valid, x_out_ale, x_out_is_store, x_out_signed;
    logic [1:0]  x_out_size;
    logic [2:0]  x_out_offset;
    logic [2:0]  x_outst_cnt;

    ex_lsu_stage_if #(.DATA_W(64), .ADDR_W(32)) bus64();

    ex_lsu_stage #(.DATA_W(64), .ADDR_W(32), .MAX_OUTST(2)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(x_in_valid), .in_ready(x_in_ready), .in_is_store(x_in_is_store),
        .in_size(x_in_size), .in_signed(x_in_signed), .in_addr(x_in_addr),
        .in_wdata(x_in_wdata), .flush(x_flush), .bus(bus64),
        .resp_fwd(x_resp_fwd), .out_valid(x_out_valid), .out_ready(x_out_ready),
        .out_ale(x_out_ale), .out_is_store(x_out_is_store), .out_size(x_out_size),
        .out_signed(x_out_signed), .out_offset(x_out_offset), .outst_cnt(x_outst_cnt)
    );

    // ---------------- model of the 32-bit instance ----------------
    typedef struct { int id; bit live; } fl_t;
    fl_t q[$];
    int          next_id = 0;
    bit          m_pend = 0, m_pend_dead = 0, m_p_store = 0, m_p_signed = 0;
    logic [1:0]  m_p_size = 0;
    logic [31:0] m_p_addr = 0, m_p_wdata = 0;
    int          m_p_id = 0;
    bit          m_slot_v = 0, m_s_ale = 0, m_s_store = 0, m_s_signed = 0;
    logic [1:0]  m_s_size = 0;
    logic [31:0] m_s_addr = 0;
    int          m_s_id = 0;

    function automatic bit f_ale(logic [1:0] size, logic [31:0] addr);
        int bytes = 1 << size;
        return (bytes > 4) || ((addr % bytes) != 0);
    endfunction

    function automatic logic [3:0] f_wstrb(bit st, logic [1:0] size, logic [31:0] addr);
        int bytes = 1 << size;
        int m;
        if (!st) return 4'b0000;
        m = ((1 << bytes) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] f_wdata(logic [1:0] size, logic [31:0] d);
        int bytes = 1 << size;
        logic [31:0] r = 0;
        logic [7:0]  b;
        for (int i = 0; i < 4; i++) begin
            b = 8'(d >> (8 * (i % bytes)));
            r = r | (32'(b) << (8 * i));
        end
        return r;
    endfunction

    function automatic bit exp_ready();
        return !m_pend && !flush && (q.size() < 2) && (!m_slot_v || out_ready);
    endfunction

    task automatic model_step();
        bit acc;
        bit live;
        acc = in_valid && exp_ready();
        if (bus32.data_ok && q.size() > 0) q.delete(0);
        if (flush && m_slot_v && !m_s_ale)
            foreach (q[k]) if (q[k].id == m_s_id) q[k].live = 0;
        if (m_slot_v && out_ready) m_slot_v = 0;
        if (m_pend && bus32.addr_ok) begin
            live = !(m_pend_dead || flush);
            q.push_back('{m_p_id, live});
            if (live) begin
                m_slot_v = 1; m_s_ale = 0; m_s_store = m_p_store;
                m_s_signed = m_p_signed; m_s_size = m_p_size;
                m_s_addr = m_p_addr; m_s_id = m_p_id;
            end
            m_pend = 0;
        end else if (m_pend && flush) begin
            m_pend_dead = 1;
        end
        if (acc) begin
            if (f_ale(in_size, in_addr)) begin
                m_slot_v = 1; m_s_ale = 1; m_s_store = in_is_store;
                m_s_signed = in_signed; m_s_size = in_size; m_s_addr = in_addr;
            end else begin
                m_pend = 1; m_pend_dead = 0; m_p_store = in_is_store;
                m_p_signed = in_signed; m_p_size = in_size; m_p_addr = in_addr;
                m_p_wdata = in_wdata; m_p_id = next_id; next_id++;
            end
        end
        if (flush) m_slot_v = 0;
    endtask

    // Model advances on every clock edge and clears on reset.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_pend = 0; m_pend_dead = 0; m_slot_v = 0;
            end else begin
                model_step();
            end
        end
    end

    task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the 32-bit instance against the model.
    initial begin
        bit exp_resp;
        forever begin
            @(negedge clk);
            exp_resp = 0;
            if (bus32.data_ok) exp_resp = (q.size() == 0) ? 1'b1 : q[0].live;
            check_output("m.in_ready", in_ready, exp_ready());
            check_output("m.req", bus32.req, m_pend);
            check_output("m.outst_cnt", outst_cnt, q.size());
            check_output("m.resp_fwd", resp_fwd, exp_resp);
            check_output("m.out_valid", out_valid, m_slot_v);
            if (m_slot_v) begin
                check_output("m.out_ale", out_ale, m_s_ale);
                check_output("m.out_is_store", out_is_store, m_s_store);
                check_output("m.out_size", out_size, m_s_size);
                check_output("m.out_signed", out_signed, m_s_signed);
                check_output("m.out_offset", out_offset, m_s_addr[1:0]);
            end
            if (m_pend) begin
                check_output("m.req_wr", bus32.req_wr, m_p_store);
                check_output("m.req_size", bus32.req_size, m_p_size);
                check_output("m.req_addr", bus32.req_addr, m_p_addr);
                check_output("m.req_wstrb", bus32.req_wstrb, f_wstrb(m_p_store, m_p_size, m_p_addr));
                check_output("m.req_wdata", bus32.req_wdata, f_wdata(m_p_size, m_p_wdata));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(bit v, bit st, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        in_valid    = v;
        in_is_store = st;
        in_size     = sz;
        in_signed   = ~st;
        in_addr     = a;
        in_wdata    = d;
    endtask

    initial begin
        apply_stimulus(0, 0, 0, 0, 0);
        flush = 0; out_ready = 1; bus32.addr_ok = 0; bus32.data_ok = 0;
        x_in_valid = 0; x_in_is_store = 0; x_in_size = 0; x_in_signed = 0;
        x_in_addr = 0; x_in_wdata = 0; x_flush = 0; x_out_ready = 1;
        bus64.addr_ok = 0; bus64.data_ok = 0;

        repeat (2) cyc();
        reset = 0;
        mid();
        check_output("rst.out_valid", out_valid, 0);
        check_output("rst.req", bus32.req, 0);
        check_output("rst.outst_cnt", outst_cnt, 0);
        check_output("rst.in_ready", in_ready, 1);

        // store half at 0x1002, addr_ok on the first request cycle
        cyc(); apply_stimulus(1, 1, 1, 32'h1002, 32'h0000ABCD);
        cyc(); apply_stimulus(0, 0, 0, 0, 0); bus32.addr_ok = 1;
        mid();
        check_output("sh.req", bus32.req, 1);
        check_output("sh.wstrb", bus32.req_wstrb, 4'b1100);
        check_output("sh.wdata", bus32.req_wdata, 32'hABCDABCD);
        cyc(); bus32.addr_ok = 0;
        mid();
        check_output("sh.outst_cnt", outst_cnt, 1);
        check_output("sh.out_valid", out_valid, 1);
        check_output("sh.out_ale", out_ale, 0);
        cyc(); bus32.data_ok = 1;
        mid();
        check_output("sh.resp_fwd", resp_fwd, 1);
        cyc(); bus32.data_ok = 0;

        // misaligned word load, then doubleword on a 32-bit bus
        apply_stimulus(1, 0, 2, 32'h1001, 0);
        cyc(); apply_stimulus(0, 0, 0, 0, 0);
        mid();
        check_output("lw_mis.out_valid", out_valid, 1);
        check_output("lw_mis.out_ale", out_ale, 1);
        check_output("lw_mis.req", bus32.req, 0);
        cyc(); apply_stimulus(1, 0, 3, 32'h1000, 0);
        cyc(); apply_stimulus(0, 0, 0, 0, 0);
        mid();
        check_output("ld32.out_ale", out_ale, 1);
        cyc();

        // fill to MAX_OUTST with responses withheld
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1, 0, 0, 32'h2003 + i, 0);
            cyc(); apply_stimulus(0, 0, 0, 0, 0); bus32.addr_ok = 1;
            cyc(); bus32.addr_ok = 0;
        end
        apply_stimulus(1, 0, 2, 32'h2010, 0);
        mid();
        check_output("full.in_ready", in_ready, 0);
        check_output("full.outst_cnt", outst_cnt, 2);
        cyc(); apply_stimulus(0, 0, 0, 0, 0); bus32.data_ok = 1;
        cyc(); bus32.data_ok = 0; apply_stimulus(1, 0, 2, 32'h2010, 0);
        cyc(); apply_stimulus(0, 0, 0, 0, 0); bus32.addr_ok = 1; bus32.data_ok = 1;
        cyc(); bus32.addr_ok = 0; bus32.data_ok = 0;
        mid();
        check_output("same.outst_cnt", outst_cnt, 1);
        cyc(); bus32.data_ok = 1;
        cyc(); bus32.data_ok = 0;

        // flush while the request waits 3 cycles for addr_ok
        apply_stimulus(1, 0, 2, 32'h3000, 0);
        cyc(); apply_stimulus(0, 0, 0, 0, 0); flush = 1;
        cyc(); flush = 0;
        cyc();
        cyc(); bus32.addr_ok = 1;
        mid();
        check_output("fl.req_held", bus32.req, 1);
        cyc(); bus32.addr_ok = 0;
        mid();
        check_output("fl.out_valid", out_valid, 0);
        check_output("fl.outst_cnt", outst_cnt, 1);
        cyc(); bus32.data_ok = 1;
        mid();
        check_output("fl.resp_drop", resp_fwd, 0);
        cyc(); bus32.data_ok = 0; apply_stimulus(1, 0, 2, 32'h3004, 0);
        cyc(); apply_stimulus(0, 0, 0, 0, 0); bus32.addr_ok = 1;
        cyc(); bus32.addr_ok = 0; bus32.data_ok = 1;
        mid();
        check_output("fl.resp_live", resp_fwd, 1);
        cyc(); bus32.data_ok = 0;

        // flush of an issued op parked in the slot
        out_ready = 0; apply_stimulus(1, 0, 1, 32'h4002, 0);
        cyc(); apply_stimulus(0, 0, 0, 0, 0); bus32.addr_ok = 1;
        cyc(); bus32.addr_ok = 0; flush = 1;
        cyc(); flush = 0; out_ready = 1; bus32.data_ok = 1;
        mid();
        check_output("slotfl.out_valid", out_valid, 0);
        check_output("slotfl.resp_drop", resp_fwd, 0);
        cyc(); bus32.data_ok = 0;

        // flush with nothing in flight blocks the offered op
        flush = 1; apply_stimulus(1, 1, 2, 32'h4100, 32'h12345678);
        mid();
        check_output("idlefl.in_ready", in_ready, 0);
        cyc(); flush = 0; apply_stimulus(0, 0, 0, 0, 0);
        mid();
        check_output("idlefl.req", bus32.req, 0);
        cyc();

        // 64-bit bus: byte store at lane 7, doubleword load
        x_in_valid = 1; x_in_is_store = 1; x_in_size = 0;
        x_in_addr = 32'h0000_0107; x_in_wdata = 64'h5A;
        cyc(); x_in_valid = 0; bus64.addr_ok = 1;
        mid();
        check_output("w64.sb.wstrb", bus64.req_wstrb, 8'h80);
        check_output("w64.sb.wdata", bus64.req_wdata, 64'h5A5A5A5A5A5A5A5A);
        cyc(); bus64.addr_ok = 0;
        mid();
        check_output("w64.sb.out_offset", x_out_offset, 3'd7);
        x_in_valid = 1; x_in_is_store = 0; x_in_size = 3; x_in_addr = 32'h0000_0108;
        cyc(); x_in_valid = 0; bus64.addr_ok = 1;
        mid();
        check_output("w64.ld.req", bus64.req, 1);
        check_output("w64.ld.wstrb", bus64.req_wstrb, 8'h00);
        cyc(); bus64.addr_ok = 0;
        mid();
        check_output("w64.ld.out_ale", x_out_ale, 0);
        check_output("w64.ld.out_offset", x_out_offset, 3'd0);
        check_output("w64.ld.outst_cnt", x_outst_cnt, 2);
        cyc(); bus64.data_ok = 1;
        cyc();
        cyc(); bus64.data_ok = 0;
        mid();
        check_output("w64.drain", x_outst_cnt, 0);

        // reset while a request is pending with one already outstanding
        cyc(); apply_stimulus(1, 0, 2, 32'h5000, 0);
        cyc(); apply_stimulus(0, 0, 0, 0, 0); bus32.addr_ok = 1;
        cyc(); bus32.addr_ok = 0; apply_stimulus(1, 0, 2, 32'h5004, 0);
        cyc(); apply_stimulus(0, 0, 0, 0, 0);
        mid();
        check_output("rreq.req", bus32.req, 1);
        check_output("rreq.outst_cnt", outst_cnt, 1);
        #1 reset = 1;
        #1;
        check_output("rreq.req_clr", bus32.req, 0);
        check_output("rreq.outst_clr", outst_cnt, 0);
        check_output("rreq.in_ready", in_ready, 1);
        cyc(); reset = 0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
